// File: rtl/debug_loader.sv
// Host-driven program/debug loader: writes IMEM/DMEM, reads the register file and gates the core reset.
// Define DEBUG_LOADER_READBACK_EN to enable register-file readback (op 10); otherwise op 10 is rejected.
module debug_loader #(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024,
    parameter int AW         = 10,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [63:0]   cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [63:0]   rsp_data,
    output logic          rsp_err,
    output logic          core_reset_out,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [63:0]   dmem_wdata,
    output logic [4:0]    rf_raddr,
    input  logic [63:0]   rf_rdata
);
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
`ifdef DEBUG_LOADER_READBACK_EN
        READ,
        CAPTURE,
`endif
        RESP
    } state_t;

    state_t           state_reg;
    logic [1:0]       op_reg;
    logic             running_reg;
    logic [CNT_W-1:0] wr_count_reg;
    logic [CNT_W-1:0] wr_count_next;
    logic             cmd_reject;
    logic             cmd_accept;

    assign wr_count_next = wr_count_reg + CNT_W'(1);
    assign cmd_accept    = cmd_valid && cmd_ready && (state_reg == IDLE);

    // Writes are refused while the core runs so the loader never races the fetch/data path.
    always_comb begin
        cmd_reject = 1'b0;
        case (cmd_op)
            2'b00:   cmd_reject = running_reg || (32'(cmd_addr) >= IMEM_DEPTH);
            2'b01:   cmd_reject = running_reg || (32'(cmd_addr) >= DMEM_DEPTH);
`ifdef DEBUG_LOADER_READBACK_EN
            2'b10:   cmd_reject = 1'b0;
`else
            2'b10:   cmd_reject = 1'b1;
`endif
            default: cmd_reject = 1'b0;
        endcase
    end

`ifdef DEBUG_LOADER_READBACK_EN
    logic [4:0] rf_raddr_reg;
    assign rf_raddr = rf_raddr_reg;
`else
    logic unused_rdata;
    assign rf_raddr     = 5'd0;
    assign unused_rdata = ^rf_rdata;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            op_reg         <= 2'b00;
            running_reg    <= 1'b0;
            wr_count_reg   <= '0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            core_reset_out <= 1'b1;
            imem_we        <= 1'b0;
            imem_addr      <= '0;
            imem_wdata     <= '0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
`ifdef DEBUG_LOADER_READBACK_EN
            rf_raddr_reg   <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cmd_ready <= !cmd_accept;
                    if (cmd_accept) begin
                        op_reg <= cmd_op;
                        if (cmd_reject) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state_reg <= RESP;
                        end else begin
                            case (cmd_op)
                                2'b00: begin
                                    imem_we    <= 1'b1;
                                    imem_addr  <= cmd_addr;
                                    imem_wdata <= cmd_data[31:0];
                                    state_reg  <= WRITE;
                                end
                                2'b01: begin
                                    dmem_we    <= 1'b1;
                                    dmem_addr  <= cmd_addr;
                                    dmem_wdata <= cmd_data;
                                    state_reg  <= WRITE;
                                end
`ifdef DEBUG_LOADER_READBACK_EN
                                2'b10: begin
                                    rf_raddr_reg <= cmd_addr[4:0];
                                    state_reg    <= READ;
                                end
`endif
                                default: begin
                                    // Report the run state the core will have once this response is taken.
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b0;
                                    rsp_data  <= {63'b0, ~running_reg};
                                    state_reg <= RESP;
                                end
                            endcase
                        end
                    end
                end
                WRITE: begin
                    wr_count_reg <= wr_count_next;
                    rsp_valid    <= 1'b1;
                    rsp_err      <= 1'b0;
                    rsp_data     <= {{(64-CNT_W){1'b0}}, wr_count_next};
                    state_reg    <= RESP;
                end
`ifdef DEBUG_LOADER_READBACK_EN
                READ: begin
                    state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= rf_rdata;
                    state_reg <= RESP;
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                        cmd_ready <= 1'b1;
                        state_reg <= IDLE;
                        if (op_reg == 2'b11) begin
                            running_reg    <= ~running_reg;
                            core_reset_out <= running_reg;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
